// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// The master side drives requests; the slave (FIFO) side drives data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-full/empty levels, sticky error
// flags and a choice between registered and first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);

  generate
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must lie in 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              empty;
  logic              full;
  logic              rd_acc;
  logic              wr_acc;

  // count never exceeds DEPTH, so its top bit alone marks the full state.
  assign empty  = (count_q == '0);
  assign full   = count_q[ADDR_W];
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new error event takes priority over a simultaneous clear.
      if (bus.wr_en && !wr_acc) overflow_q <= 1'b1;
      else if (bus.clr_err)     overflow_q <= 1'b0;
      if (bus.rd_en && empty)   underflow_q <= 1'b1;
      else if (bus.clr_err)     underflow_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout       = mem_q[rd_ptr_q];
      assign bus.dout_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              dout_valid_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem_q[rd_ptr_q];
        end
      end
      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: fixed vector table, hand-written corner sequences
// and random traffic checked against a queue-based model, in both read modes.
module tb_sync_fifo_param;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_f;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bs ();
  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bf ();

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0))
    u_std (.clk(clk), .rst(rst_s), .bus(bs));
  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst_f), .bus(bf));

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus the registered read port and flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_dv;
  logic          m_ov;
  logic          m_un;

  typedef struct {
    logic          r, w, rd, c;
    logic [DW-1:0] din;
    int            cnt;
    logic          dv;
    logic [DW-1:0] dout;
    logic          full, empty, af, ae, ov, un;
  } vec_t;
  vec_t vt[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int m, input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic c);
    bit e, f, ra, wa;
    if (m == 0) begin
      rst_s = r; bs.wr_en = w; bs.din = d; bs.rd_en = rd; bs.clr_err = c;
    end else begin
      rst_f = r; bf.wr_en = w; bf.din = d; bf.rd_en = rd; bf.clr_err = c;
    end
    if (!r) begin
      mq.delete();
      m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      e  = (mq.size() == 0);
      f  = (mq.size() == DEPTH);
      ra = rd && !e;
      wa = w && (!f || ra);
      m_ov = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ov);
      m_un = (rd && e)  ? 1'b1 : (c ? 1'b0 : m_un);
      m_dv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int m, input string tag);
    logic [AW:0]   a_cnt;
    logic [DW-1:0] a_dout;
    logic          a_dv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    int            n;
    if (m == 0) begin
      a_cnt = bs.count; a_dout = bs.dout; a_dv = bs.dout_valid; a_full = bs.full;
      a_empty = bs.empty; a_af = bs.almost_full; a_ae = bs.almost_empty;
      a_ov = bs.overflow; a_un = bs.underflow;
    end else begin
      a_cnt = bf.count; a_dout = bf.dout; a_dv = bf.dout_valid; a_full = bf.full;
      a_empty = bf.empty; a_af = bf.almost_full; a_ae = bf.almost_empty;
      a_ov = bf.overflow; a_un = bf.underflow;
    end
    n = mq.size();
    chk({tag, ".count"}, 32'(a_cnt), n);
    chk({tag, ".empty"}, 32'(a_empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(a_full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(a_af), 32'(n >= AF));
    chk({tag, ".almost_empty"}, 32'(a_ae), 32'(n <= AE));
    chk({tag, ".overflow"}, 32'(a_ov), 32'(m_ov));
    chk({tag, ".underflow"}, 32'(a_un), 32'(m_un));
    if (m == 0) begin
      chk({tag, ".dout_valid"}, 32'(a_dv), 32'(m_dv));
      chk({tag, ".dout"}, 32'(a_dout), 32'(m_dout));
    end else begin
      chk({tag, ".dout_valid"}, 32'(a_dv), 32'(n != 0));
      if (n != 0) chk({tag, ".dout"}, 32'(a_dout), 32'(mq[0]));
    end
  endtask

  task automatic run_random(input int m, input int cycles);
    logic r, w, rd, c;
    int   pw;
    for (int i = 0; i < cycles; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 30;
      r  = ($urandom_range(0, 99) != 0);
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < 100 - pw);
      c  = ($urandom_range(0, 99) < 6);
      step(m, r, w, DW'($urandom), rd, c);
      check_model(m, $sformatf("rnd%0d[%0d]", m, i));
    end
  endtask

  initial begin
    rst_s = 1'b0; rst_f = 1'b0;
    bs.wr_en = 0; bs.din = '0; bs.rd_en = 0; bs.clr_err = 0;
    bf.wr_en = 0; bf.din = '0; bf.rd_en = 0; bf.clr_err = 0;

    //          r  w  rd c  din     cnt dv dout   full empty af ae ov un
    vt[0]  = '{0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 8'h11, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 8'h22, 2, 0, 8'h00, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 8'h33, 3, 0, 8'h00, 0, 0, 1, 0, 0, 0};
    vt[4]  = '{1, 1, 0, 0, 8'h44, 4, 0, 8'h00, 1, 0, 1, 0, 0, 0};
    vt[5]  = '{1, 1, 0, 0, 8'h55, 4, 0, 8'h00, 1, 0, 1, 0, 1, 0};
    vt[6]  = '{1, 0, 0, 1, 8'h00, 4, 0, 8'h00, 1, 0, 1, 0, 0, 0};
    vt[7]  = '{1, 1, 1, 0, 8'h55, 4, 1, 8'h11, 1, 0, 1, 0, 0, 0};
    vt[8]  = '{1, 0, 1, 0, 8'h00, 3, 1, 8'h22, 0, 0, 1, 0, 0, 0};
    vt[9]  = '{1, 0, 1, 0, 8'h00, 2, 1, 8'h33, 0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 1, 0, 8'h00, 1, 1, 8'h44, 0, 0, 0, 1, 0, 0};
    vt[11] = '{1, 0, 1, 0, 8'h00, 0, 1, 8'h55, 0, 1, 0, 1, 0, 0};
    vt[12] = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h55, 0, 1, 0, 1, 0, 0};
    vt[13] = '{1, 1, 1, 0, 8'hA5, 1, 0, 8'h55, 0, 0, 0, 1, 0, 1};
    vt[14] = '{1, 0, 1, 0, 8'h00, 0, 1, 8'hA5, 0, 1, 0, 1, 0, 1};
    vt[15] = '{1, 0, 0, 1, 8'h00, 0, 0, 8'hA5, 0, 1, 0, 1, 0, 0};
    vt[16] = '{1, 0, 1, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 0, 1, 0, 1};
    vt[17] = '{1, 1, 0, 0, 8'h01, 1, 0, 8'hA5, 0, 0, 0, 1, 0, 1};
    vt[18] = '{1, 1, 0, 0, 8'h02, 2, 0, 8'hA5, 0, 0, 0, 0, 0, 1};
    vt[19] = '{0, 1, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    vt[20] = '{1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1};

    for (int i = 0; i < 21; i++) begin
      step(0, vt[i].r, vt[i].w, vt[i].din, vt[i].rd, vt[i].c);
      chk($sformatf("vec%0d.count", i), 32'(bs.count), vt[i].cnt);
      chk($sformatf("vec%0d.dout_valid", i), 32'(bs.dout_valid), 32'(vt[i].dv));
      chk($sformatf("vec%0d.dout", i), 32'(bs.dout), 32'(vt[i].dout));
      chk($sformatf("vec%0d.full", i), 32'(bs.full), 32'(vt[i].full));
      chk($sformatf("vec%0d.empty", i), 32'(bs.empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d.almost_full", i), 32'(bs.almost_full), 32'(vt[i].af));
      chk($sformatf("vec%0d.almost_empty", i), 32'(bs.almost_empty), 32'(vt[i].ae));
      chk($sformatf("vec%0d.overflow", i), 32'(bs.overflow), 32'(vt[i].ov));
      chk($sformatf("vec%0d.underflow", i), 32'(bs.underflow), 32'(vt[i].un));
    end

    // Ten write/read pairs walk both pointers around the 4-entry ring more than twice.
    step(0, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] v;
      v = DW'(i * 37 + 5);
      step(0, 1, 1, v, 0, 0);
      chk($sformatf("wrap%0d.count_after_wr", i), 32'(bs.count), 1);
      step(0, 1, 0, 8'h00, 1, 0);
      chk($sformatf("wrap%0d.dout", i), 32'(bs.dout), 32'(v));
      chk($sformatf("wrap%0d.dout_valid", i), 32'(bs.dout_valid), 1);
      chk($sformatf("wrap%0d.count_after_rd", i), 32'(bs.count), 0);
    end

    run_random(0, 400);

    // FWFT: the written word must appear on dout without any read request.
    step(1, 0, 0, 8'h00, 0, 0);
    chk("fwft.reset.empty", 32'(bf.empty), 1);
    chk("fwft.reset.dout_valid", 32'(bf.dout_valid), 0);
    step(1, 1, 1, 8'h3C, 0, 0);
    chk("fwft.wr.dout", 32'(bf.dout), 32'h3C);
    chk("fwft.wr.dout_valid", 32'(bf.dout_valid), 1);
    step(1, 1, 0, 8'h00, 0, 0);
    chk("fwft.hold.dout", 32'(bf.dout), 32'h3C);
    step(1, 1, 0, 8'h00, 1, 0);
    chk("fwft.pop.empty", 32'(bf.empty), 1);
    chk("fwft.pop.dout_valid", 32'(bf.dout_valid), 0);
    check_model(1, "fwft.pop");

    run_random(1, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
